// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Optional feature macro used by the top: ARB_MAXBURST_EN.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_N = 4;

  function automatic int arb_id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W = arb_id_w(ARB_N);

  // Expects a one-hot or all-zero vector; all-zero maps to index 0.
  function automatic int unsigned onehot2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_picker.sv
// Combinational round-robin picker: lowest set request at or after the pointer,
// wrapping modulo N, found with a double-width mask and a lowest-set-bit isolate.
module rr_picker
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = arb_id_w(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_pick_oh,
  output logic           o_pick_vld
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_mask;
  logic [2*N-1:0] w_masked;
  logic [2*N-1:0] w_lowest;

  // The upper copy catches requests below the pointer, giving the wrap-around.
  assign w_dbl      = {i_req, i_req};
  assign w_mask     = ~(((2*N)'(1) << i_ptr) - (2*N)'(1));
  assign w_masked   = w_dbl & w_mask;
  assign w_lowest   = w_masked & (~w_masked + (2*N)'(1));
  assign o_pick_oh  = w_lowest[N-1:0] | w_lowest[2*N-1:N];
  assign o_pick_vld = |i_req;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that locks the grant for a whole burst under a ready handshake.
// Define ARB_MAXBURST_EN to force a release after MAX_BEATS accepted beats.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int N         = ARB_N,
  parameter int MAX_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           req_last,
  input  logic                   res_ready,
  output logic [N-1:0]           gnt,
  output logic                   gnt_vld,
  output logic [arb_id_w(N)-1:0] gnt_id,
  output logic                   beat_fire
);

  localparam int IDW = arb_id_w(N);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [N-1:0]   r_gnt;
  logic [N-1:0]   w_gnt_nxt;
  logic           r_gnt_vld;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_gnt_id;
  logic [IDW-1:0] w_ptr_inc;
  logic [IDW-1:0] w_pick_ptr;
  logic [N-1:0]   w_pick_oh;
  logic           w_pick_vld;
  logic           w_beat_fire;
  logic           w_last_beat;
  logic           w_abandon;
  logic           w_max_hit;
  logic           w_release;

  assign w_gnt_id    = IDW'(onehot2bin(32'(r_gnt)));
  assign w_ptr_inc   = (w_gnt_id == IDW'(N - 1)) ? '0 : w_gnt_id + IDW'(1);
  assign w_beat_fire = r_gnt_vld & res_ready & req[w_gnt_id];
  assign w_last_beat = w_beat_fire & req_last[w_gnt_id];
  assign w_abandon   = r_gnt_vld & ~req[w_gnt_id];
  assign w_release   = (r_state == BUSY) & (w_last_beat | w_abandon | w_max_hit);

  // On release the next owner is chosen in the same cycle from the advanced pointer.
  assign w_pick_ptr  = w_release ? w_ptr_inc : r_ptr;

`ifdef ARB_MAXBURST_EN
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic [CNT_W-1:0] r_beat_cnt;

  assign w_max_hit = w_beat_fire & (r_beat_cnt == CNT_W'(MAX_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
    end else if (w_release) begin
      r_beat_cnt <= '0;
    end else if (w_beat_fire) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_max_beats;

  assign w_max_hit          = 1'b0;
  assign w_unused_max_beats = (MAX_BEATS > 0);
`endif

  rr_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_picker (
    .i_req      (req),
    .i_ptr      (w_pick_ptr),
    .o_pick_oh  (w_pick_oh),
    .o_pick_vld (w_pick_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = BUSY;
          w_gnt_nxt   = w_pick_oh;
        end
      end
      BUSY: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_inc;
          if (w_pick_vld) begin
            w_gnt_nxt = w_pick_oh;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= |w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_vld   = r_gnt_vld;
  assign gnt_id    = w_gnt_id;
  assign beat_fire = w_beat_fire;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: directed scenarios plus random traffic
// compared against a behavioural owner/pointer model.
module tb_rr_burst_arbiter;
  import arb_pkg::*;

  localparam int N         = 4;
  localparam int MAX_BEATS = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic           res_ready;
  logic [N-1:0]   gnt;
  logic           gnt_vld;
  logic [ID_W-1:0] gnt_id;
  logic           beat_fire;

  int tests_run;
  int tests_failed;

  int m_owner;
  int m_ptr;
  int m_cnt;

  rr_burst_arbiter #(
    .N         (N),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_last  (req_last),
    .res_ready (res_ready),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld),
    .gnt_id    (gnt_id),
    .beat_fire (beat_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] e;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    return e;
  endfunction

  function automatic logic exp_fire();
    return (m_owner >= 0) && res_ready && req[m_owner];
  endfunction

  // Reference: the owner keeps the port until its last accepted beat, an abandon,
  // or (with the limit) its MAX_BEATS-th beat; then scan from the next index.
  task automatic model_step();
    logic fire;
    logic rel;
    if (m_owner < 0) begin
      m_owner = first_from(req, m_ptr);
    end else begin
      fire = res_ready && req[m_owner];
      rel  = !req[m_owner] || (fire && req_last[m_owner]);
`ifdef ARB_MAXBURST_EN
      if (fire && (m_cnt + 1 == MAX_BEATS)) rel = 1'b1;
`endif
      if (rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_cnt   = 0;
        m_owner = first_from(req, m_ptr);
      end else if (fire) begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
    req       = r;
    req_last  = l;
    res_ready = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_last  = '0;
    res_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; req_last = '0; res_ready = 1'b0;
    model_reset();
    #3;
    tests_run++;
    if (gnt !== '0 || gnt_vld !== 1'b0 || gnt_id !== '0 || beat_fire !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got gnt=%b vld=%b id=%0d fire=%b, want 0000/0/0/0",
               gnt, gnt_vld, gnt_id, beat_fire);
    end
    do_reset();
  endtask

  task automatic test_all_req();
    logic [N-1:0] want;
    do_reset();
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    tests_run++;
    if (gnt !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL all_req_idle: got %b want 0000", gnt);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      want = 4'b0001 << (i % 4);
      tests_run++;
      if (gnt !== want || gnt !== exp_gnt() || beat_fire !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL all_req_rotate cycle %0d: got gnt=%b fire=%b want gnt=%b fire=1",
                 i, gnt, beat_fire, want);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0011, (i == 2) ? 4'b0001 : 4'b0000, 1'b1);
      tests_run++;
      if (gnt !== 4'b0001 || beat_fire !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL handoff_hold beat %0d: got gnt=%b fire=%b want 0001/1",
                 i, gnt, beat_fire);
      end
      tick();
    end
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    tests_run++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_vld !== 1'b1 || gnt !== exp_gnt()) begin
      tests_failed++;
      $display("[TB] FAIL handoff_next: got gnt=%b id=%0d vld=%b want 0010/1/1",
               gnt, gnt_id, gnt_vld);
    end
  endtask

  task automatic test_stall();
    do_reset();
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, (i == 2) ? 4'b1111 : 4'b0000, 1'b0);
      tests_run++;
      if (gnt !== 4'b0010 || beat_fire !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stall cycle %0d: got gnt=%b fire=%b want 0010/0", i, gnt, beat_fire);
      end
      tick();
    end
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    tests_run++;
    if (gnt !== 4'b0010 || beat_fire !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stall_resume: got gnt=%b fire=%b want 0010/1", gnt, beat_fire);
    end
  endtask

  task automatic test_single();
    do_reset();
    applyStimulus(4'b0100, 4'b0100, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || beat_fire !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL single_regrant cycle %0d: got gnt=%b id=%0d fire=%b want 0100/2/1",
                 i, gnt, gnt_id, beat_fire);
      end
      tick();
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tests_run++;
    if (beat_fire !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_drop_fire: got %b want 0", beat_fire);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_id !== '0) begin
      tests_failed++;
      $display("[TB] FAIL single_drop_idle: got gnt=%b vld=%b id=%0d want 0000/0/0",
               gnt, gnt_vld, gnt_id);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    tick();
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    tick();
    tests_run++;
    if (gnt !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL async_no_preempt: got %b want 1000", gnt);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_clear: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin
      tests_failed++;
      $display("[TB] FAIL async_first_pick: got %b want 0001", gnt);
    end
  endtask

  task automatic test_maxburst();
    logic [N-1:0] want;
    do_reset();
    applyStimulus(4'b0011, 4'b0000, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
`ifdef ARB_MAXBURST_EN
      want = ((i / MAX_BEATS) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
      want = 4'b0001;
`endif
      tests_run++;
      if (gnt !== want || gnt !== exp_gnt() || beat_fire !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL maxburst beat %0d: got gnt=%b fire=%b want %b/1",
                 i, gnt, beat_fire, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic         rd;
    int           want_id;
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      l  = '0;
      for (int b = 0; b < N; b++) l[b] = ($urandom_range(3) == 0);
      rd = ($urandom_range(3) != 0);
      applyStimulus(r, l, rd);
      want_id = (m_owner < 0) ? 0 : m_owner;
      tests_run++;
      if (gnt !== exp_gnt() || gnt_vld !== (m_owner >= 0) ||
          gnt_id !== ID_W'(want_id) || beat_fire !== exp_fire()) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: got gnt=%b vld=%b id=%0d fire=%b want gnt=%b vld=%b id=%0d fire=%b",
                 i, gnt, gnt_vld, gnt_id, beat_fire, exp_gnt(), (m_owner >= 0), want_id, exp_fire());
      end
      tick();
    end
  endtask

  // Release as seen from the ports; the limit term needs the model's beat count.
  logic tb_rel;
  always_comb begin
    tb_rel = !req[gnt_id] || (beat_fire && req_last[gnt_id]);
`ifdef ARB_MAXBURST_EN
    if (beat_fire && (m_cnt + 1 == MAX_BEATS)) tb_rel = 1'b1;
`endif
  end

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                             (gnt_vld && !tb_rel) |=> $stable(gnt));

  for (genvar g = 0; g < N; g++) begin : g_cov
    c_gnt: cover property (@(posedge clk) gnt == (N'(1) << g));
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = '0;
    req_last     = '0;
    res_ready    = 1'b0;
    model_reset();
    test_reset();
    test_all_req();
    test_handoff();
    test_stall();
    test_single();
    test_async_reset();
    test_maxburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
